ifmap_glb_bank: RTL

- Storage responder behind the access-control port mux: the dual-port ifmap global buffer itself.
- Port A (FIFO_WIDTH) serves the off-chip FIFO side.
- Port B (DATA_WIDTH) serves the selected NoC/LRN/padding requester.
- Provides synchronous mixed-width reads and writes, same-cycle collision resolution, and out-of-range detection.

---
 rtl/glb_pkg.sv | 21 ++
 rtl/glb_lane_ram.sv | 61 ++++++
 rtl/ifmap_glb_bank.sv | 136 +++++++++++++
 3 files changed

// File: rtl/glb_pkg.sv
// Shared geometry for the ifmap global buffer: lane count and element/word index helpers.
package glb_pkg;

    // Elements per wide word; the bank is built from this many lanes.
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = $clog2(LANES);

    typedef logic [LANE_W-1:0] lane_idx_t;
    typedef logic [31:0]       word_idx_t;

    // Element e lives in word e / LANES.
    function automatic word_idx_t elem_to_word(input logic [31:0] elem);
        return word_idx_t'(elem >> LANE_W);
    endfunction

    // Element e lives in lane e % LANES.
    function automatic lane_idx_t elem_to_lane(input logic [31:0] elem);
        return lane_idx_t'(elem);
    endfunction

endpackage

// File: rtl/glb_lane_ram.sv
// One DATA_WIDTH-wide lane of the ifmap buffer: two write ports, two read-first read ports.
module glb_lane_ram #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Depth     = 1024,
    parameter int unsigned AddrW     = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_a_i,
    input  logic [AddrW-1:0]     waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    input  logic                 re_a_i,
    input  logic [AddrW-1:0]     raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic                 we_b_i,
    input  logic [AddrW-1:0]     waddr_b_i,
    input  logic [DataWidth-1:0] wdata_b_i,
    input  logic                 re_b_i,
    input  logic [AddrW-1:0]     raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_a_q;
    logic [DataWidth-1:0] rdata_b_q;
    logic                 a_blocked;

    // Port B owns this lane when both ports hit the same word.
    always_comb begin
        a_blocked = we_b_i && (waddr_b_i == waddr_a_i);
    end

    // Storage array; not reset.
    always_ff @(posedge clk_i) begin
        if (we_a_i && !a_blocked) begin
            mem_q[waddr_a_i] <= wdata_a_i;
        end
        if (we_b_i) begin
            mem_q[waddr_b_i] <= wdata_b_i;
        end
    end

    // Read-first output registers: sample the array before this edge's writes land.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (re_a_i) begin
                rdata_a_q <= mem_q[raddr_a_i];
            end
            if (re_b_i) begin
                rdata_b_q <= mem_q[raddr_b_i];
            end
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ifmap_glb_bank.sv
// Dual-port ifmap global buffer: wide FIFO-side port A, element-wide requester port B.
module ifmap_glb_bank
    import glb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FIFO_WIDTH  = 64,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic [FIFO_WIDTH-1:0] wdata_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [FIFO_WIDTH-1:0] rdata_a,
    input  logic                  we_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic                  addr_err
);

    localparam int unsigned WordW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LimitA = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LimitB = ADDR_WIDTH'(DEPTH_WORDS * LANES);

    logic             wa_ok, ra_ok, wb_ok, rb_ok;
    logic [WordW-1:0] wa_word, ra_word, wb_word, rb_word;
    lane_idx_t        wb_lane, rb_lane;

    logic [DATA_WIDTH-1:0] lane_rdata_a [LANES];
    logic [DATA_WIDTH-1:0] lane_rdata_b [LANES];
    logic [FIFO_WIDTH-1:0] word_rdata_a;

    logic      rvalid_a_d, rvalid_a_q, rvalid_b_d, rvalid_b_q;
    logic      rzero_a_d, rzero_a_q, rzero_b_d, rzero_b_q;
    lane_idx_t rsel_b_d, rsel_b_q;
    logic      addr_err_d, addr_err_q;

    // Range checks and address decode for both ports.
    always_comb begin
        wa_ok   = waddr_a < LimitA;
        ra_ok   = raddr_a < LimitA;
        wb_ok   = waddr_b < LimitB;
        rb_ok   = raddr_b < LimitB;
        wa_word = WordW'(waddr_a);
        ra_word = WordW'(raddr_a);
        wb_word = WordW'(elem_to_word(32'(waddr_b)));
        rb_word = WordW'(elem_to_word(32'(raddr_b)));
        wb_lane = elem_to_lane(32'(waddr_b));
        rb_lane = elem_to_lane(32'(raddr_b));
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        glb_lane_ram #(
            .DataWidth (DATA_WIDTH),
            .Depth     (DEPTH_WORDS)
        ) u_lane (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .we_a_i    (we_a && wa_ok),
            .waddr_a_i (wa_word),
            .wdata_a_i (wdata_a[l*DATA_WIDTH +: DATA_WIDTH]),
            .re_a_i    (re_a && ra_ok),
            .raddr_a_i (ra_word),
            .rdata_a_o (lane_rdata_a[l]),
            .we_b_i    (we_b && wb_ok && (wb_lane == lane_idx_t'(l))),
            .waddr_b_i (wb_word),
            .wdata_b_i (wdata_b),
            .re_b_i    (re_b && rb_ok && (rb_lane == lane_idx_t'(l))),
            .raddr_b_i (rb_word),
            .rdata_b_o (lane_rdata_b[l])
        );
    end

    // Next state for valids, zero-forcing flags, B lane select and the sticky error.
    always_comb begin
        rvalid_a_d = re_a;
        rvalid_b_d = re_b;
        rzero_a_d  = rzero_a_q;
        rzero_b_d  = rzero_b_q;
        rsel_b_d   = rsel_b_q;
        addr_err_d = addr_err_q;
        // Flags only move on an accepted read so rdata holds otherwise.
        if (re_a) begin
            rzero_a_d = !ra_ok;
        end
        if (re_b) begin
            rzero_b_d = !rb_ok;
            rsel_b_d  = rb_lane;
        end
        if ((we_a && !wa_ok) || (re_a && !ra_ok) || (we_b && !wb_ok) || (re_b && !rb_ok)) begin
            addr_err_d = 1'b1;
        end
    end

    // Read-side control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rzero_a_q  <= 1'b0;
            rzero_b_q  <= 1'b0;
            rsel_b_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rzero_a_q  <= rzero_a_d;
            rzero_b_q  <= rzero_b_d;
            rsel_b_q   <= rsel_b_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Assemble the wide word and apply the out-of-range zeroing.
    always_comb begin
        word_rdata_a = '0;
        for (int l = 0; l < LANES; l++) begin
            word_rdata_a[l*DATA_WIDTH +: DATA_WIDTH] = lane_rdata_a[l];
        end
        rdata_a = rzero_a_q ? '0 : word_rdata_a;
        rdata_b = rzero_b_q ? '0 : lane_rdata_b[rsel_b_q];
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign addr_err = addr_err_q;

endmodule
